mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller with architectural HI/LO.
//
// Purpose: launches MULT/MULTU (5 cycles) and DIV/DIVU (10 cycles) from the
// EX stage, holds Busy while an op is in flight, and commits {HI,LO} on the
// edge that ends the last RUN cycle. MTHI/MTLO write HI/LO in a single edge
// and never set Busy.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (accumulate the
// 64-bit product onto {HI,LO}, 5 cycles). When it is undefined, Op 6/7 are
// no-ops and there is no accumulate adder.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset
//   Start  in   1  launch request for Op this cycle
//   Flush  in   1  squash; suppresses a same-cycle launch only
//   Op     in   3  0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU
//   A      in  32  rs operand
//   B      in  32  rt operand
//   Busy   out  1  multicycle op in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Flush,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  // Counter is loaded with (latency - 1) and the commit happens when it is 0.
  localparam logic [3:0] MUL_LAST = 4'd4;
  localparam logic [3:0] DIV_LAST = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;

  // Launch decode
  logic        launch_d;
  logic [3:0]  cnt_d;

  always_comb begin
    launch_d = 1'b0;
    cnt_d    = MUL_LAST;
    if (state_q == IDLE && Start && !Flush) begin
      case (Op)
        OP_MULT, OP_MULTU: begin launch_d = 1'b1; cnt_d = MUL_LAST; end
        OP_DIV,  OP_DIVU:  begin launch_d = 1'b1; cnt_d = DIV_LAST; end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin launch_d = 1'b1; cnt_d = MUL_LAST; end
`endif
        default: ;
      endcase
    end
  end

  // Result datapath, evaluated from the latched operands
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur;
  logic [31:0] res_hi_d, res_lo_d;

  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD);
    mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
    mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
    // Low 64 bits of the sign/zero-extended product are exact for both.
    prod    = mul_a * mul_b;

    // Signed divide done on magnitudes: quotient sign = sa^sb, remainder
    // takes the dividend's sign (truncation toward zero).
    div_sgn = (op_q == OP_DIV);
    a_neg   = div_sgn & a_q[31];
    b_neg   = div_sgn & b_q[31];
    a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
    uq      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    ur      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);

    res_hi_d = hi_q;
    res_lo_d = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {res_hi_d, res_lo_d} = prod;
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi_d = a_q;
          res_lo_d = 32'hFFFF_FFFF;
        end else if (div_sgn && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          res_hi_d = 32'd0;
          res_lo_d = 32'h8000_0000;
        end else begin
          res_lo_d = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
          res_hi_d = a_neg ? (~ur + 32'd1) : ur;
        end
      end
`ifdef MDU_MADD_EN
      // HI/LO cannot change during RUN, so this is the launch-edge value.
      OP_MADD, OP_MADDU: {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_d) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_d;
            op_q    <= Op;
            a_q     <= A;
            b_q     <= B;
          end else if (Start && !Flush && Op == OP_MTHI) begin
            hi_q <= A;
          end else if (Start && !Flush && Op == OP_MTLO) begin
            lo_q <= A;
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of HI/LO/Busy.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, Start, Flush;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Op(Op),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: HI/LO, cycles left in flight, pending result
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic [63:0] r;
    int sa, sb;
    sa = a;
    sb = b;
    r  = {hi, lo};
    case (op)
      3'd0: r = longint'(sa) * longint'(sb);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      3'd6: r = {hi, lo} + 64'(longint'(sa) * longint'(sb));
      3'd7: r = {hi, lo} + {32'd0, a} * {32'd0, b};
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (Start && !Flush) begin
      case (Op)
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        3'd0, 3'd1: begin m_pend = ref_result(Op, A, B, m_hi, m_lo); m_left = 5; end
        3'd2, 3'd3: begin m_pend = ref_result(Op, A, B, m_hi, m_lo); m_left = 10; end
`ifdef MDU_MADD_EN
        3'd6, 3'd7: begin m_pend = ref_result(Op, A, B, m_hi, m_lo); m_left = 5; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", 64'(Busy), 64'(m_left > 0));
    chk("hi", 64'(HI), 64'(m_hi));
    chk("lo", 64'(LO), 64'(m_lo));
  endtask

  // Launch op, hold Busy for lat cycles, optionally fire a stray Start mid-run.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int stray_at);
    Start = 1; Flush = 0; Op = op; A = a; B = b;
    cycle();
    Start = 0; A = $urandom; B = $urandom;
    chk({tag, "_busy1"}, 64'(Busy), 64'd1);
    for (int i = 2; i <= lat; i++) begin
      if (i == stray_at) begin Start = 1; Op = 3'd1; end
      cycle();
      Start = 0;
      chk({tag, "_busyN"}, 64'(Busy), 64'd1);
    end
    cycle();
    chk({tag, "_done"}, 64'(Busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1; Start = 0; Flush = 0; Op = 0; A = 0; B = 0;
    m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
    cycle(); cycle();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    reset = 0;

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, -1);
    chk("mult_res", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, -1);
    chk("div_res", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op("divu0", 3'd3, 32'd7, 32'd0, 10, -1);
    chk("divu0_res", {HI, LO}, {32'd7, 32'hFFFF_FFFF});

    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, -1);
    chk("divovf_res", {HI, LO}, {32'd0, 32'h8000_0000});

    // MTLO single edge, Busy stays low
    Start = 1; Op = 3'd5; A = 32'h1234_5678;
    cycle();
    Start = 0;
    chk("mtlo_lo", 64'(LO), 64'h1234_5678);
    chk("mtlo_busy", 64'(Busy), 64'd0);
    // Flushed MTHI: no change
    Start = 1; Flush = 1; Op = 3'd4; A = 32'hDEAD_BEEF;
    cycle();
    Start = 0; Flush = 0;
    chk("flush_hi", 64'(HI), 64'd0);

    // Stray MULTU during a DIV is ignored
    run_op("divstray", 3'd2, 32'd100, 32'd7, 10, 3);
    chk("divstray_res", {HI, LO}, {32'd2, 32'd14});

    // Reset pulse in cycle 3 of a DIV
    Start = 1; Op = 3'd2; A = 32'd50; B = 32'd3;
    cycle();
    Start = 0;
    cycle(); cycle();
    #2 reset = 1;
    #1;
    m_hi = 0; m_lo = 0; m_left = 0;
    chk("rstmid_busy", 64'(Busy), 64'd0);
    chk("rstmid_hilo", {HI, LO}, 64'd0);
    #1 reset = 0;
    repeat (12) cycle();
    chk("rstmid_nocommit", {HI, LO}, 64'd0);

`ifdef MDU_MADD_EN
    Start = 1; Op = 3'd4; A = 32'd0; cycle();
    Op = 3'd5; A = 32'd10; cycle();
    run_op("maddu", 3'd7, 32'd2, 32'd3, 5, -1);
    chk("maddu_res", {HI, LO}, {32'd0, 32'd16});
`else
    Start = 1; Op = 3'd7; A = 32'd2; B = 32'd3;
    cycle();
    Start = 0;
    chk("madd_noop_busy", 64'(Busy), 64'd0);
    chk("madd_noop_hilo", {HI, LO}, 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Start = ($urandom % 2) == 0;
      Flush = ($urandom % 5) == 0;
      Op    = 3'($urandom % 8);
      A     = pick();
      B     = pick();
      reset = ($urandom % 400) == 0;
      cycle();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
